uart_tx_arbiter: RTL and testbench

//  Shares one uart transmitter among NUM_REQ requesters with round-robin arbitration.

---
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Round-robin arbiter sharing one UART transmitter among NUM_REQ
//           byte producers; each frame is tracked to completion via uart_ready.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_BITS     = 8,
  parameter int START_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_BITS-1:0]         uart_tx_input,
  output logic                         uart_new_data,
  input  logic                         uart_ready,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         start_err,
  output logic [15:0]                  frame_count
);

  localparam int c_id_w = $clog2(NUM_REQ);
  localparam int c_to_w = $clog2(START_TIMEOUT + 1);
  localparam logic [c_id_w-1:0] c_last_id = c_id_w'(NUM_REQ - 1);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [c_id_w-1:0]   r_rr_ptr;
  logic [c_id_w-1:0]   r_grant;
  logic [c_id_w-1:0]   w_winner;
  logic [c_id_w-1:0]   w_next_ptr;
  logic [DATA_BITS-1:0] r_tx_data;
  logic                r_first;
  logic                r_start_err;
  logic [c_to_w-1:0]   r_timeout;
  logic [15:0]         r_frame_count;
  logic                w_found;
  logic                w_launch;
  logic                w_done;
  logic                w_abort;
  logic                w_timeout_hit;
  int                  w_idx;
  logic [DATA_BITS-1:0] w_req_byte [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_byte
    assign w_req_byte[gi] = req_data[gi*DATA_BITS +: DATA_BITS];
  end

  // First valid requester at or above the rr pointer, wrapping past the top
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_rr_ptr;
    w_idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && req_valid[c_id_w'(w_idx)]) begin
        w_found  = 1'b1;
        w_winner = c_id_w'(w_idx);
      end
    end
  end

  assign w_next_ptr    = (r_grant == c_last_id) ? '0 : r_grant + 1'b1;
  assign w_timeout_hit = (r_timeout == c_to_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && uart_ready && w_found) begin
          w_state_next = S_LAUNCH;
          w_launch     = 1'b1;
        end
      end
      S_LAUNCH: begin
        // A falling uart_ready wins over a timeout landing on the same edge
        if (!uart_ready) begin
          w_state_next = S_WAIT_DONE;
        end else if (w_timeout_hit) begin
          w_state_next = S_IDLE;
          w_abort      = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (uart_ready) begin
          w_state_next = S_IDLE;
          w_done       = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr      <= '0;
      r_grant       <= '0;
      r_tx_data     <= '0;
      r_first       <= 1'b0;
      r_start_err   <= 1'b0;
      r_timeout     <= '0;
      r_frame_count <= '0;
    end else begin
      r_first     <= w_launch;
      r_start_err <= w_abort;
      if (w_launch) begin
        r_grant   <= w_winner;
        r_tx_data <= w_req_byte[w_winner];
        r_timeout <= '0;
      end else if (r_state == S_LAUNCH) begin
        r_timeout <= r_timeout + 1'b1;
      end
      // Aborted frames still advance the pointer so a stuck uart cannot starve others
      if (w_abort || w_done) begin
        r_rr_ptr <= w_next_ptr;
      end
      if (w_done) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign req_ready     = (r_state == S_LAUNCH && r_first) ? (NUM_REQ'(1) << r_grant) : '0;
  assign uart_new_data = (r_state == S_LAUNCH);
  assign busy          = (r_state != S_IDLE);
  assign uart_tx_input = r_tx_data;
  assign grant_id      = r_grant;
  assign start_err     = r_start_err;
  assign frame_count   = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Brief   : Randomised bench for uart_tx_arbiter with a transaction-level
//           reference model, a simple uart model and directed scenarios.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int DATA_BITS     = 8;
  localparam int START_TIMEOUT = 16;
  localparam int CPB           = 4;
  localparam int FRAME         = 10 * CPB;

  logic                         clk       = 1'b0;
  logic                         rst_n     = 1'b0;
  logic                         enable    = 1'b0;
  logic [NUM_REQ-1:0]           req_valid = '0;
  logic [NUM_REQ*DATA_BITS-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]           req_ready;
  logic [DATA_BITS-1:0]         uart_tx_input;
  logic                         uart_new_data;
  logic                         uart_ready = 1'b1;
  logic [1:0]                   grant_id;
  logic                         busy;
  logic                         start_err;
  logic [15:0]                  frame_count;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DATA_BITS    (DATA_BITS),
    .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .uart_tx_input(uart_tx_input),
    .uart_new_data(uart_new_data),
    .uart_ready   (uart_ready),
    .grant_id     (grant_id),
    .busy         (busy),
    .start_err    (start_err),
    .frame_count  (frame_count)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Uart model: accepts new_data when idle, holds ready low for a 10-bit frame
  logic       u_stuck = 1'b0;
  logic       tx_wire = 1'b1;
  logic [9:0] u_frame = '1;
  int         u_tick  = 0;
  logic [7:0] sent_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_ready <= 1'b1;
      tx_wire    <= 1'b1;
      u_tick     <= 0;
    end else if (uart_ready) begin
      if (uart_new_data && !u_stuck) begin
        uart_ready <= 1'b0;
        u_frame    <= {1'b1, uart_tx_input, 1'b0};
        u_tick     <= 0;
        tx_wire    <= 1'b0;
        sent_q.push_back(uart_tx_input);
      end
    end else if (u_tick == FRAME - 1) begin
      uart_ready <= 1'b1;
      tx_wire    <= 1'b1;
    end else begin
      u_tick  <= u_tick + 1;
      tx_wire <= u_frame[(u_tick + 1) / CPB];
    end
  end

  // Reference model: arbitration outcome and frame bookkeeping per clock
  function automatic int pick(input logic [NUM_REQ-1:0] v, input int rr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(rr + k) % NUM_REQ]) return (rr + k) % NUM_REQ;
    end
    return 0;
  endfunction

  int                   m_phase = 0;  // 0 idle, 1 launching, 2 frame on the wire
  int                   m_age   = 0;
  int                   m_rr    = 0;
  int                   m_win   = 0;
  logic [NUM_REQ-1:0]   e_rdy   = '0;
  logic                 e_err   = 1'b0;
  logic [1:0]           e_grant = '0;
  logic [DATA_BITS-1:0] e_tx    = '0;
  logic [15:0]          e_cnt   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_age <= 0; m_rr <= 0; m_win <= 0;
      e_rdy <= '0; e_err <= 1'b0; e_grant <= '0; e_tx <= '0; e_cnt <= '0;
    end else begin
      e_rdy <= '0;
      e_err <= 1'b0;
      if (m_phase == 0) begin
        if (enable && uart_ready && req_valid != '0) begin
          m_win   <= pick(req_valid, m_rr);
          e_grant <= 2'(pick(req_valid, m_rr));
          e_tx    <= req_data[pick(req_valid, m_rr)*DATA_BITS +: DATA_BITS];
          e_rdy   <= NUM_REQ'(1) << pick(req_valid, m_rr);
          m_phase <= 1;
          m_age   <= 1;
        end
      end else if (m_phase == 1) begin
        if (!uart_ready) begin
          m_phase <= 2;
        end else if (m_age == START_TIMEOUT) begin
          m_phase <= 0;
          e_err   <= 1'b1;
          m_rr    <= (m_win + 1) % NUM_REQ;
        end else begin
          m_age <= m_age + 1;
        end
      end else if (uart_ready) begin
        m_phase <= 0;
        e_cnt   <= e_cnt + 16'd1;
        m_rr    <= (m_win + 1) % NUM_REQ;
      end
    end
  end

  always @(negedge clk) begin
    chk("req_ready",     req_ready,     e_rdy);
    chk("uart_new_data", uart_new_data, m_phase == 1);
    chk("busy",          busy,          m_phase != 0);
    chk("start_err",     start_err,     e_err);
    chk("grant_id",      grant_id,      e_grant);
    chk("uart_tx_input", uart_tx_input, e_tx);
    chk("frame_count",   frame_count,   e_cnt);
  end

  // Requester behaviour: after an accept, either drop valid or present a new byte
  logic [NUM_REQ-1:0] acc_pend = '0;
  logic [NUM_REQ-1:0] hold     = '0;
  int                 grant_q[$];
  int                 ready_pulses = 0;

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc_pend[i]) begin
        if (hold[i]) req_data[i*DATA_BITS +: DATA_BITS] = 8'($urandom);
        else         req_valid[i] = 1'b0;
      end
    end
    acc_pend = req_ready;
    if (req_ready != '0) begin
      grant_q.push_back(int'(grant_id));
      ready_pulses++;
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] d);
    req_valid[i] = 1'b1;
    req_data[i*DATA_BITS +: DATA_BITS] = d;
  endtask

  task automatic wait_quiet(input int max_cyc);
    int n;
    n = 0;
    while ((req_valid != '0 || acc_pend != '0 || busy || !uart_ready) && n < max_cyc) begin
      tick();
      n++;
    end
    chk("quiet_within_budget", n < max_cyc, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"},   req_ready,     0);
    chk({tag, "_new_data"},    uart_new_data, 0);
    chk({tag, "_tx_input"},    uart_tx_input, 0);
    chk({tag, "_grant_id"},    grant_id,      0);
    chk({tag, "_busy"},        busy,          0);
    chk({tag, "_start_err"},   start_err,     0);
    chk({tag, "_frame_count"}, frame_count,   0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         s;
    int         g;
    int         r0;
    int         seen;
    logic [9:0] frame_bits;
    logic       tx_moved;
    logic [15:0] cnt0;

    repeat (3) tick();
    chk_all_zero("reset");
    rst_n  = 1'b1;
    enable = 1'b1;
    tick();

    // Single requester, byte 0xA5 observed on the serial line
    set_req(0, 8'hA5);
    n = 0;
    while (uart_ready && n < 20) begin tick(); n++; end
    chk("t1_uart_started", uart_ready, 0);
    for (int j = 0; j < 10; j++) begin
      frame_bits[j] = tx_wire;
      repeat (CPB) tick();
    end
    chk("t1_tx_wire_frame", frame_bits, 10'h34A);
    wait_quiet(200);
    chk("t1_frame_count", frame_count, 1);
    chk("t1_ready_pulses", ready_pulses, 1);
    chk("t1_busy", busy, 0);

    // Fresh reset, then all four requesters at once
    rst_n = 1'b0;
    tick();
    chk_all_zero("rst2");
    rst_n = 1'b1;
    tick();
    g = grant_q.size();
    s = sent_q.size();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'(8'h11 * (i + 1)));
    wait_quiet(400);
    chk("t2_grants", grant_q.size() - g, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_grant_order", grant_q[g + k], k);
      chk("t2_byte_order", sent_q[s + k], 8'(8'h11 * (k + 1)));
    end
    chk("t2_frame_count", frame_count, 4);

    // Two persistent requesters must alternate
    g = grant_q.size();
    hold[0] = 1'b1;
    hold[2] = 1'b1;
    set_req(0, 8'h0F);
    set_req(2, 8'hF0);
    n = 0;
    while (grant_q.size() < g + 4 && n < 600) begin tick(); n++; end
    hold = '0;
    chk("t3_grant_budget", n < 600, 1);
    chk("t3_g0", grant_q[g + 0], 0);
    chk("t3_g1", grant_q[g + 1], 2);
    chk("t3_g2", grant_q[g + 2], 0);
    chk("t3_g3", grant_q[g + 3], 2);
    wait_quiet(400);

    // Arbitration disabled: request is left waiting
    enable   = 1'b0;
    r0       = ready_pulses;
    s        = sent_q.size();
    tx_moved = 1'b0;
    set_req(1, 8'h3C);
    for (int c = 0; c < 200; c++) begin
      tick();
      if (tx_wire !== 1'b1) tx_moved = 1'b1;
    end
    chk("t4_no_ready", ready_pulses - r0, 0);
    chk("t4_tx_idle", tx_moved, 0);
    chk("t4_no_launch", sent_q.size() - s, 0);
    enable = 1'b1;
    seen   = 0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      if (uart_new_data && seen == 0) seen = k;
    end
    chk("t4_new_data_within_2clk", seen != 0, 1);
    wait_quiet(200);

    // Uart never starts: timeout pulse exactly START_TIMEOUT cycles after launch
    u_stuck = 1'b1;
    cnt0    = frame_count;
    set_req(3, 8'h5A);
    n = 0;
    while (req_ready == '0 && n < 20) begin tick(); n++; end
    chk("t5_launched", req_ready, 4'b1000);
    n = 0;
    while (!start_err && n < 40) begin tick(); n++; end
    chk("t5_err_latency", n, START_TIMEOUT);
    chk("t5_new_data_low", uart_new_data, 0);
    chk("t5_idle", busy, 0);
    chk("t5_count_kept", frame_count, cnt0);
    u_stuck = 1'b0;
    wait_quiet(200);

    // Reset in the middle of a frame, then a clean transfer
    set_req(1, 8'hC3);
    n = 0;
    while (!(uart_ready == 1'b0 && u_tick == 4 * CPB) && n < 200) begin tick(); n++; end
    chk("t6_reached_bit4", n < 200, 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t6_async");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    s = sent_q.size();
    set_req(2, 8'h81);
    wait_quiet(200);
    chk("t6_sent", sent_q.size() - s, 1);
    if (sent_q.size() > s) chk("t6_byte", sent_q[s], 8'h81);
    chk("t6_frame_count", frame_count, 1);

    // Randomised traffic with enable toggles and occasional stuck uart
    for (int c = 0; c < 2500; c++) begin
      tick();
      for (int i = 0; i < NUM_REQ; i++) begin
        hold[i] = ($urandom_range(0, 3) == 0);
        if (!req_valid[i] && !acc_pend[i] && $urandom_range(0, 5) == 0)
          set_req(i, 8'($urandom));
      end
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      if (!u_stuck && $urandom_range(0, 299) == 0) u_stuck = 1'b1;
      else if (u_stuck && $urandom_range(0, 29) == 0) u_stuck = 1'b0;
    end
    enable  = 1'b1;
    u_stuck = 1'b0;
    hold    = '0;
    wait_quiet(3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
